// File: rtl/tag_ctrl_pkg.sv
// Shared types and timing constants for the tag enable controller.
// Holds the mode and state enums plus 80 MHz slot timing presets.
package tag_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_SHORT = 2'd0,
    MODE_LONG  = 2'd1,
    MODE_HOLD  = 2'd2,
    MODE_OFF   = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SLOT = 2'd1,
    ST_GAP  = 2'd2,
    ST_COOL = 2'd3
  } state_t;

  localparam int CLK_MHZ = 80;
  localparam int US_10   = 800;
  localparam int US_100  = 8000;

endpackage

// File: rtl/tag_slot_scheduler_slot_timer.sv
// slot_timer: loadable down-counter, done high while count is zero.
// Ports: clk, rst (async high), load, len (phase length minus one), done.
module slot_timer #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] len,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= len;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  // A phase of N clocks is loaded with N-1; done marks its last cycle.
  assign done = (cnt == '0);

endmodule

// File: rtl/tag_slot_scheduler.sv
// tag_slot_scheduler: rotating one-hot tag enables with gap and cool-down.
// Ports: clk, rst, mode_step/mode_load/mode_in, tag_mask, hold_sel -> tag_en, slot_idx, frame_start, mode.
module tag_slot_scheduler
  import tag_ctrl_pkg::*;
#(
  parameter int TAG_NUM    = 4,
  parameter int CNT_W      = 32,
  parameter int SLOT_SHORT = US_10,
  parameter int SLOT_LONG  = US_100,
  parameter int GAP_CYC    = 0,
  parameter int COOL_CYC   = US_100,
  parameter int IDX_W      = $clog2(TAG_NUM)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mode_step,
  input  logic               mode_load,
  input  logic [1:0]         mode_in,
  input  logic [TAG_NUM-1:0] tag_mask,
  input  logic [IDX_W-1:0]   hold_sel,
  output logic [TAG_NUM-1:0] tag_en,
  output logic [IDX_W-1:0]   slot_idx,
  output logic               frame_start,
  output logic [1:0]         mode
);

  if (SLOT_SHORT < 1 || SLOT_LONG < 1) begin : g_bad_len
    $error("slot length must be at least 1");
  end
  if (TAG_NUM < 2 || TAG_NUM > 16) begin : g_bad_num
    $error("TAG_NUM must be 2..16");
  end

  localparam logic [IDX_W-1:0] LAST     = IDX_W'(TAG_NUM - 1);
  localparam logic [CNT_W-1:0] SHORT_M1 = CNT_W'(SLOT_SHORT - 1);
  localparam logic [CNT_W-1:0] LONG_M1  = CNT_W'(SLOT_LONG - 1);
  localparam logic [CNT_W-1:0] GAP_M1   = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] COOL_M1  = CNT_W'(COOL_CYC - 1);

  function automatic logic [TAG_NUM-1:0] onehot(input logic [IDX_W-1:0] i);
    onehot = '0;
    if (int'(i) < TAG_NUM) onehot[i] = 1'b1;
  endfunction

  state_t             st, st_n;
  mode_t              mode_q, mode_n;
  logic [IDX_W-1:0]   idx_q, idx_n;
  logic [TAG_NUM-1:0] en_q, en_n;
  logic               fs_q, fs_n;
  logic               ld, done;
  logic [CNT_W-1:0]   ld_val;
  logic               adv, go_slot;
  logic [IDX_W-1:0]   go_idx;
  logic [CNT_W-1:0]   slot_m1;

  assign slot_m1 = (mode_q == MODE_LONG) ? LONG_M1 : SHORT_M1;

  slot_timer #(.CNT_W(CNT_W)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .load (ld),
    .len  (ld_val),
    .done (done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st     <= ST_IDLE;
      mode_q <= MODE_SHORT;
    end else begin
      st     <= st_n;
      mode_q <= mode_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q <= '0;
      en_q  <= '0;
      fs_q  <= 1'b0;
    end else begin
      idx_q <= idx_n;
      en_q  <= en_n;
      fs_q  <= fs_n;
    end
  end

  always_comb begin
    st_n    = st;
    mode_n  = mode_q;
    idx_n   = idx_q;
    en_n    = '0;
    fs_n    = 1'b0;
    ld      = 1'b0;
    ld_val  = '0;
    adv     = 1'b0;
    go_slot = 1'b0;
    go_idx  = '0;

    if (mode_load || mode_step) begin
      // Restart: one forced IDLE cycle with enables low.
      mode_n = mode_load ? mode_t'(mode_in)
                         : mode_t'(mode_q + 2'd1);
      st_n   = ST_IDLE;
      idx_n  = '0;
      ld     = 1'b1;
    end else begin
      unique case (mode_q)
        MODE_HOLD: begin
          st_n  = ST_IDLE;
          idx_n = hold_sel;
          en_n  = onehot(hold_sel) & tag_mask;
        end
        MODE_OFF: begin
          st_n  = ST_IDLE;
          idx_n = '0;
        end
        default: begin
          unique case (st)
            ST_IDLE: go_slot = 1'b1;
            ST_SLOT: begin
              en_n = en_q;
              if (done) begin
                en_n = '0;
                if (GAP_CYC != 0) begin
                  st_n   = ST_GAP;
                  ld     = 1'b1;
                  ld_val = GAP_M1;
                end else begin
                  adv = 1'b1;
                end
              end
            end
            ST_GAP:  adv = done;
            ST_COOL: go_slot = done;
            default: st_n = ST_IDLE;
          endcase
        end
      endcase
    end

    if (adv) begin
      if (idx_q != LAST) begin
        go_slot = 1'b1;
        go_idx  = idx_q + 1'b1;
      end else if (COOL_CYC != 0) begin
        st_n   = ST_COOL;
        ld     = 1'b1;
        ld_val = COOL_M1;
      end else begin
        go_slot = 1'b1;
      end
    end

    // Mask is captured here and held for the whole slot.
    if (go_slot) begin
      st_n   = ST_SLOT;
      idx_n  = go_idx;
      en_n   = onehot(go_idx) & tag_mask;
      fs_n   = (go_idx == '0);
      ld     = 1'b1;
      ld_val = slot_m1;
    end
  end

  assign tag_en      = en_q;
  assign slot_idx    = idx_q;
  assign frame_start = fs_q;
  assign mode        = mode_q;

endmodule

// File: doc/tag_slot_scheduler.md
Name: tag_slot_scheduler

Overview:
Parametrised time-division controller for backscatter tag enables. It drives TAG_NUM one-hot enable lines in rotating slots, with a programmable inter-slot gap and an end-of-frame cool-down. It supports four runtime modes (short slots, long slots, hold a single tag, off) and a per-tag mask. It sits between the debounced key / control logic and the tag ctrl pins, clocked from the 80 MHz domain.

Parameters:
TAG_NUM, 4, number of tag enable outputs (2..16)
CNT_W, 32, width of the phase counter
SLOT_SHORT, 800, slot length in clocks in mode 0 (10 us at 80 MHz)
SLOT_LONG, 8000, slot length in clocks in mode 1 (100 us)
GAP_CYC, 0, idle clocks after each slot; 0 means no gap phase
COOL_CYC, 8000, idle clocks at end of frame; 0 means no cool phase
IDX_W, $clog2(TAG_NUM), width of the slot index

Ports:
clk  in  1  system clock (80 MHz)
rst  in  1  asynchronous reset, active-high
mode_step  in  1  single-cycle pulse: advance mode (mode+1) mod 4 and restart
mode_load  in  1  single-cycle pulse: load mode_in and restart; has priority over mode_step
mode_in  in  2  mode value for mode_load
tag_mask  in  TAG_NUM  per-tag enable mask; 1 = tag allowed
hold_sel  in  IDX_W  tag held active in mode 2
tag_en  out  TAG_NUM  registered enable lines, at most one bit high
slot_idx  out  IDX_W  current slot index, or hold_sel in mode 2
frame_start  out  1  one-cycle pulse on the first cycle of slot 0
mode  out  2  current mode: 0 SHORT, 1 LONG, 2 HOLD, 3 OFF

Behaviour:
- Clock and reset: one clock (clk). rst is asynchronous and active-high. While rst is high: tag_en=0, slot_idx=0, frame_start=0, mode=0, state=IDLE, counter=0.
- All outputs are registered. No combinational path runs from any input to any output.
- States: IDLE, SLOT, GAP, COOL.
- IDLE:
  - In modes 0 and 1, IDLE lasts exactly one clock.
  - It then enters SLOT with slot_idx=0, counter=0 and frame_start=1 for that cycle.
  - In modes 2 and 3 the block stays in IDLE.
- SLOT:
  - Slot length L is SLOT_SHORT in mode 0 and SLOT_LONG in mode 1.
  - tag_en = onehot(slot_idx) & tag_mask, held for exactly L clocks.
  - tag_mask is sampled once, on slot entry. A mask change mid-slot takes effect at the next slot.
  - A masked slot still consumes L clocks with tag_en=0, so frame timing is mask-independent.
- GAP: lasts GAP_CYC clocks with tag_en=0. The GAP state is skipped when GAP_CYC=0.
- Slot advance:
  - After the gap of slot i < TAG_NUM-1, go to SLOT i+1.
  - After the gap of the last slot, go to COOL.
- COOL: lasts COOL_CYC clocks with tag_en=0, then goes to SLOT 0 with a frame_start pulse. There is no IDLE cycle on a frame wrap.
- Frame timing: period = TAG_NUM*(L+GAP_CYC)+COOL_CYC clocks. frame_start pulses exactly once per period.
- Mode 2 HOLD:
  - tag_en = onehot(hold_sel) & tag_mask, updated every clock.
  - slot_idx = hold_sel. frame_start stays 0.
  - If hold_sel >= TAG_NUM, tag_en=0.
- Mode 3 OFF: tag_en=0, slot_idx=0, frame_start=0.
- Mode change (mode_load or mode_step):
  - The new mode is registered on the cycle after the pulse.
  - On that same cycle the state goes to IDLE, the counter clears and tag_en=0. This is a guaranteed break-before-make of at least one clock.
  - The frame then restarts from slot 0 as defined above.
  - If mode_load and mode_step are asserted together, only mode_load acts.
  - Restarting into the same mode (load of the current mode) still restarts the frame.
- Counter: saturation is never reached, because lengths must satisfy length-1 < 2^CNT_W. A length parameter of 0 for a slot is illegal; flag it with an elaboration-time assertion.
- Mid-operation reset: outputs drop asynchronously. After release, the block behaves exactly as after power-up.

Decomposition:
- Shared package tag_ctrl_pkg holds:
  - the mode enum (MODE_SHORT=0, MODE_LONG=1, MODE_HOLD=2, MODE_OFF=3);
  - the state enum;
  - timing constants CLK_MHZ=80, US_10=800, US_100=8000.
- One sub-module is natural: slot_timer, a loadable down-counter with a done pulse. It is reused for the SLOT, GAP and COOL phases.

Test Plan:
1. TAG_NUM=4, SLOT_SHORT=10, GAP_CYC=2, COOL_CYC=5, mask=4'hF, mode 0 -> frame_start every 53 clocks; tag_en walks 1,2,4,8, each high 10 clocks with 2-clock gaps; 5-clock cool-down.
2. mode_step during slot 2 of mode 0 -> next cycle mode=1 and tag_en=0 for 1 clock; then frame_start with tag_en=4'h1 for 20 clocks (SLOT_LONG=20).
3. mask=4'b1010 -> slots 0 and 2 show tag_en=0 for 10 clocks each; period stays 53.
4. mode_load mode_in=2, hold_sel=3 -> tag_en=4'h8 held indefinitely, no frame_start; then hold_sel=5 with TAG_NUM=8 and mask bit 5 low -> tag_en=0.
5. mode_load and mode_step in the same cycle with mode_in=3 -> mode=3, tag_en=0 permanently.
6. rst asserted mid-slot 1 -> tag_en=0 immediately (asynchronously); after release, mode=0 and the frame restarts from slot 0 after one IDLE clock.
